// File: rtl/monitor_bateria.sv
// Battery-state model: charge level drains while running, refills while docked,
// and drives the low-battery flag (with hysteresis) and its blink alert.
module monitor_bateria #(
  parameter int NIVEL_MAX     = 8,
  parameter int NIVEL_BAIXO   = 1,
  parameter int NIVEL_RELIGA  = 3,
  parameter int TICK_DESCARGA = 50,
  parameter int TICK_CARGA    = 20,
  parameter int PISCA         = 25
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sistema_ligado,
  input  logic                           carregando,
  output logic                           bateria,
  output logic [$clog2(NIVEL_MAX+1)-1:0] nivel,
  output logic                           carga_completa,
  output logic                           alerta
);

  localparam int NW   = $clog2(NIVEL_MAX+1);
  localparam int TMAX = (TICK_DESCARGA > TICK_CARGA) ? TICK_DESCARGA : TICK_CARGA;
  localparam int PW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (PISCA > 1) ? $clog2(PISCA) : 1;

  localparam logic [PW-1:0] TD_LAST = PW'(TICK_DESCARGA - 1);
  localparam logic [PW-1:0] TC_LAST = PW'(TICK_CARGA - 1);
  localparam logic [BW-1:0] PS_LAST = BW'(PISCA - 1);
  localparam logic [NW-1:0] N_MAX   = NW'(NIVEL_MAX);
  localparam logic [NW-1:0] N_BAIXO = NW'(NIVEL_BAIXO);
  localparam logic [NW-1:0] N_RELIG = NW'(NIVEL_RELIGA);
  localparam logic [NW-1:0] N_ONE   = NW'(1);

  typedef enum logic [1:0] {REPOUSO, DESCARGA, CARGA, VAZIA} estado_t;

  estado_t       estado_q, estado_d;
  logic [NW-1:0] nivel_q, nivel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          bateria_q, bateria_d;
  logic          cc_q, cc_d;
  logic          alerta_q, alerta_d;
  logic          tick_d, tick_c;

  assign tick_d = (presc_q == TD_LAST);
  assign tick_c = (presc_q == TC_LAST);

  always_comb begin
    estado_d = estado_q;
    nivel_d  = nivel_q;
    case (estado_q)
      REPOUSO: begin
        if (carregando)                      estado_d = CARGA;
        else if (sistema_ligado && !bateria_q) estado_d = DESCARGA;
      end
      DESCARGA: begin
        if (carregando)           estado_d = CARGA;
        else if (!sistema_ligado) estado_d = REPOUSO;
        else if (tick_d && nivel_q != '0) begin
          nivel_d = nivel_q - N_ONE;
          if (nivel_q == N_ONE) estado_d = VAZIA;
        end
      end
      CARGA: begin
        if (!carregando) estado_d = REPOUSO;
        else if (tick_c && nivel_q != N_MAX) nivel_d = nivel_q + N_ONE;
      end
      VAZIA: begin
        if (carregando) estado_d = CARGA;
      end
    endcase
  end

  // Prescaler restarts on any state change so a short visit never moves the level.
  always_comb begin
    presc_d = '0;
    if (estado_d == estado_q) begin
      if (estado_q == DESCARGA)   presc_d = tick_d ? '0 : presc_q + PW'(1);
      else if (estado_q == CARGA) presc_d = tick_c ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    bateria_d = bateria_q;
    if (nivel_d <= N_BAIXO)      bateria_d = 1'b1;
    else if (nivel_d >= N_RELIG) bateria_d = 1'b0;
    cc_d = (estado_d == CARGA) && (nivel_d == N_MAX);
  end

  // Blink runs only while the flag stays set; the setting and clearing edges park it at 0.
  always_comb begin
    blink_d  = '0;
    alerta_d = 1'b0;
    if (bateria_q && bateria_d) begin
      if (blink_q == PS_LAST) begin
        blink_d  = '0;
        alerta_d = ~alerta_q;
      end else begin
        blink_d  = blink_q + BW'(1);
        alerta_d = alerta_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOUSO;
      nivel_q   <= N_MAX;
      presc_q   <= '0;
      blink_q   <= '0;
      bateria_q <= 1'b0;
      cc_q      <= 1'b0;
      alerta_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      nivel_q   <= nivel_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      bateria_q <= bateria_d;
      cc_q      <= cc_d;
      alerta_q  <= alerta_d;
    end
  end

  assign bateria        = bateria_q;
  assign nivel          = nivel_q;
  assign carga_completa = cc_q;
  assign alerta         = alerta_q;

endmodule

// File: tb/tb_monitor_bateria.sv
// Bench for monitor_bateria: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against a dwell-time model.
module tb_monitor_bateria;

  localparam int NMAX = 8;
  localparam int BAIXO = 1;
  localparam int RELIGA = 3;
  localparam int TD = 4;
  localparam int TC = 2;
  localparam int PS = 3;

  localparam int S_REP = 0, S_DES = 1, S_CAR = 2, S_VAZ = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sistema_ligado;
  logic       carregando;
  logic       bateria;
  logic [3:0] nivel;
  logic       carga_completa;
  logic       alerta;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model state
  int m_st, m_niv, m_bat, m_al, m_cc, m_dwell, m_bt;
  int n_st, n_niv, n_bat;

  monitor_bateria #(
    .NIVEL_MAX(NMAX), .NIVEL_BAIXO(BAIXO), .NIVEL_RELIGA(RELIGA),
    .TICK_DESCARGA(TD), .TICK_CARGA(TC), .PISCA(PS)
  ) dut (
    .clk(clk), .reset(reset), .sistema_ligado(sistema_ligado),
    .carregando(carregando), .bateria(bateria), .nivel(nivel),
    .carga_completa(carga_completa), .alerta(alerta)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: level moves when the time spent in the current state hits a multiple
  // of the tick period; alert phase is derived from time since the flag set.
  always @(posedge clk) begin
    if (reset) begin
      m_st = S_REP; m_niv = NMAX; m_bat = 0; m_al = 0; m_cc = 0;
      m_dwell = 0; m_bt = 0;
    end else begin
      n_st = m_st;
      n_niv = m_niv;
      case (m_st)
        S_REP: if (carregando) n_st = S_CAR;
               else if (sistema_ligado && m_bat == 0) n_st = S_DES;
        S_DES: if (carregando) n_st = S_CAR;
               else if (!sistema_ligado) n_st = S_REP;
               else if ((m_dwell + 1) % TD == 0) begin
                 n_niv = (m_niv > 0) ? m_niv - 1 : 0;
                 if (n_niv == 0) n_st = S_VAZ;
               end
        S_CAR: if (!carregando) n_st = S_REP;
               else if ((m_dwell + 1) % TC == 0) n_niv = (m_niv < NMAX) ? m_niv + 1 : NMAX;
        default: if (carregando) n_st = S_CAR;
      endcase
      m_dwell = (n_st != m_st) ? 0 : m_dwell + 1;
      if (n_niv <= BAIXO) n_bat = 1;
      else if (n_niv >= RELIGA) n_bat = 0;
      else n_bat = m_bat;
      if (m_bat == 1 && n_bat == 1) begin
        m_bt++;
        m_al = (m_bt / PS) % 2;
      end else begin
        m_bt = 0;
        m_al = 0;
      end
      m_cc = (n_st == S_CAR && n_niv == NMAX) ? 1 : 0;
      m_st = n_st; m_niv = n_niv; m_bat = n_bat;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("nivel", int'(nivel), m_niv);
      check("bateria", int'(bateria), m_bat);
      check("alerta", int'(alerta), m_al);
      check("carga_completa", int'(carga_completa), m_cc);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; sistema_ligado = 1'b0; carregando = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    // T1 reset
    check("t1_nivel", int'(nivel), 8);
    check("t1_bateria", int'(bateria), 0);
    check("t1_alerta", int'(alerta), 0);
    check("t1_cc", int'(carga_completa), 0);
    cyc(2);
    check("t1_idle_nivel", int'(nivel), 8);

    // T2 full drain
    sistema_ligado = 1'b1;
    cyc(4);  check("t2_before_tick", int'(nivel), 8);
    cyc(1);  check("t2_first_tick", int'(nivel), 7);
    cyc(24); check("t2_nivel1", int'(nivel), 1);
             check("t2_bat_set", int'(bateria), 1);
             check("t2_alerta_off", int'(alerta), 0);
    cyc(3);  check("t2_alerta_on", int'(alerta), 1);
    cyc(1);  check("t2_nivel0", int'(nivel), 0);
    sistema_ligado = 1'b0;
    cyc(5);  check("t2_vazia_hold", int'(nivel), 0);

    // T3 charge and hysteresis
    carregando = 1'b1;
    cyc(5);  check("t3_nivel2", int'(nivel), 2);
             check("t3_bat_hold", int'(bateria), 1);
    cyc(2);  check("t3_nivel3", int'(nivel), 3);
             check("t3_bat_clr", int'(bateria), 0);
             check("t3_alerta_clr", int'(alerta), 0);
    cyc(10); check("t3_full", int'(nivel), 8);
             check("t3_cc", int'(carga_completa), 1);
    cyc(8);  check("t3_full_hold", int'(nivel), 8);
             check("t3_cc_hold", int'(carga_completa), 1);
    carregando = 1'b0;
    cyc(1);  check("t3_cc_drop", int'(carga_completa), 0);

    // T5 short runs
    for (int i = 0; i < 4; i++) begin
      sistema_ligado = 1'b1; cyc(3);
      sistema_ligado = 1'b0; cyc(2 + i);
    end
    check("t5_nivel", int'(nivel), 8);

    // T4 simultaneous inputs at level 5
    sistema_ligado = 1'b1;
    cyc(13); check("t4_nivel5", int'(nivel), 5);
    carregando = 1'b1;
    cyc(3);  check("t4_rise", int'(nivel), 6);
    cyc(10); check("t4_full", int'(nivel), 8);
             check("t4_cc", int'(carga_completa), 1);
    carregando = 1'b0; sistema_ligado = 1'b0;
    cyc(2);

    // T6 blink then reset mid-blink
    sistema_ligado = 1'b1;
    cyc(32); check("t6_alerta_on", int'(alerta), 1);
    reset = 1'b1;
    cyc(1);  check("t6_rst_nivel", int'(nivel), 8);
             check("t6_rst_bat", int'(bateria), 0);
             check("t6_rst_alerta", int'(alerta), 0);
    reset = 1'b0; sistema_ligado = 1'b0;
    cyc(2);

    // randomized segments
    for (int s = 0; s < 250; s++) begin
      sistema_ligado = ($urandom % 3) != 0;
      carregando = ($urandom % 3) == 0;
      reset = ($urandom % 60) == 0;
      if (reset) begin
        cyc(1);
        reset = 1'b0;
      end
      cyc($urandom_range(1, 40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
